// File: rtl/unidad_control_mc.sv
// Multicycle control unit: FETCH/EXEC/HALT sequencer with opcode decode,
// zero-flag tracking and a small return-address stack for CALL/RET.
module unidad_control_mc #(
    parameter int OPW         = 6,
    parameter int PCW         = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           instr_valid,
    input  logic           zero,
    input  logic [PCW-1:0] pc_in,
    output logic           fetch_req,
    output logic           s_inc,
    output logic           s_inm,
    output logic           we3,
    output logic           wez,
    output logic [2:0]     Op,
    output logic [1:0]     s_pc,
    output logic           pc_we,
    output logic [PCW-1:0] ret_addr,
    output logic           halted,
    output logic           stack_err
);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    state_t         state, next_state;
    logic [OPW-1:0] ir;
    logic           zflag;
    logic [CW-1:0]  count;
    logic           err_q;
    logic [PCW-1:0] stack [STACK_DEPTH];

    logic [3:0]     cls;
    logic [1:0]     sub;
    logic           load_ir, zflag_we, push, pop, err_set;
    logic           full, empty;
    logic [IW-1:0]  top_idx, push_idx;

    assign cls      = ir[OPW-1 -: 4];
    assign sub      = ir[1:0];
    assign full     = (count == CW'(STACK_DEPTH));
    assign empty    = (count == '0);
    assign top_idx  = IW'(count - CW'(1));
    assign push_idx = IW'(count);

    // NOTE: every output and internal strobe gets a default before the case,
    // so no path through this block can leave a latch behind.
    always_comb begin
        next_state = state;
        load_ir    = 1'b0;
        zflag_we   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
        fetch_req  = 1'b0;
        s_inc      = 1'b0;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        Op         = 3'b000;
        s_pc       = 2'b00;
        pc_we      = 1'b0;
        ret_addr   = '0;
        halted     = 1'b0;
        stack_err  = 1'b0;

        // Reset low silences every output and suppresses all state updates.
        if (reset) begin
            case (state)
                FETCH: begin
                    fetch_req = 1'b1;
                    if (instr_valid) begin
                        load_ir    = 1'b1;
                        next_state = EXEC;
                    end
                end
                EXEC: begin
                    next_state = FETCH;
                    pc_we      = 1'b1;
                    case (cls)
                        4'b0000: begin s_inm = 1'b1; we3 = 1'b1; Op = 3'b000; end
                        4'b0001: begin s_inm = 1'b1; we3 = 1'b1; Op = 3'b010; end
                        4'b0010: begin s_inm = 1'b1; we3 = 1'b1; Op = 3'b011; end
                        4'b0011: begin s_inm = 1'b1; we3 = 1'b1; Op = 3'b110; end
                        4'b1100: s_pc = 2'b01;
                        4'b1101: if (zflag)  s_pc = 2'b01;
                        4'b1110: if (!zflag) s_pc = 2'b01;
                        4'b1111: begin
                            case (sub)
                                2'b00: begin
                                    // A CALL on a full stack degrades to a NOP.
                                    if (full) err_set = 1'b1;
                                    else begin push = 1'b1; s_pc = 2'b01; end
                                end
                                2'b01: begin
                                    if (empty) err_set = 1'b1;
                                    else begin pop = 1'b1; s_pc = 2'b10; end
                                end
                                2'b10: ;
                                default: begin
                                    next_state = HALT;
                                    pc_we      = 1'b0;
                                end
                            endcase
                        end
                        default: begin
                            we3 = 1'b1;
                            Op  = 3'(cls - 4'd4);
                        end
                    endcase
                    wez      = (cls >= 4'b0001) && (cls <= 4'b1011);
                    zflag_we = wez;
                    s_inc    = pc_we && (s_pc == 2'b00);
                end
                HALT:    halted = 1'b1;
                default: next_state = FETCH;
            endcase
            ret_addr  = empty ? '0 : stack[top_idx];
            stack_err = err_q | err_set;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            ir    <= '0;
            zflag <= 1'b0;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (load_ir)  ir    <= opcode;
            if (zflag_we) zflag <= zero;
            if (push)     count <= count + CW'(1);
            else if (pop) count <= count - CW'(1);
            if (err_set)  err_q <= 1'b1;
        end
    end

    // NOTE: stack storage has no reset; entries above count are never read,
    // so clearing count alone is enough.
    always_ff @(posedge clk) begin
        if (push) stack[push_idx] <= pc_in + PCW'(1);
    end

endmodule

// File: tb/tb_unidad_control_mc.sv
// Directed bench for unidad_control_mc: decode, jumps, CALL/RET stack,
// stack errors, HALT and reset priority.
module tb_unidad_control_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       instr_valid;
    logic       zero;
    logic [9:0] pc_in;
    logic       fetch_req, s_inc, s_inm, we3, wez, pc_we, halted, stack_err;
    logic [2:0] Op;
    logic [1:0] s_pc;
    logic [9:0] ret_addr;
    logic [10:0] ctl;

    int total  = 0;
    int passed = 0;

    // ctl = {fetch_req, s_inc, s_inm, we3, wez, Op[2:0], s_pc[1:0], pc_we}
    localparam logic [10:0] C_ZERO  = 11'b0_0_0_0_0_000_00_0;
    localparam logic [10:0] C_FETCH = 11'b1_0_0_0_0_000_00_0;
    localparam logic [10:0] C_ADI   = 11'b0_1_1_1_1_010_00_1;
    localparam logic [10:0] C_LI    = 11'b0_1_1_1_0_000_00_1;
    localparam logic [10:0] C_ALU5  = 11'b0_1_0_1_1_001_00_1;
    localparam logic [10:0] C_JUMP  = 11'b0_0_0_0_0_000_01_1;
    localparam logic [10:0] C_SEQ   = 11'b0_1_0_0_0_000_00_1;
    localparam logic [10:0] C_RET   = 11'b0_0_0_0_0_000_10_1;

    localparam logic [5:0] OP_LI   = 6'b0000_00;
    localparam logic [5:0] OP_ADI  = 6'b0001_00;
    localparam logic [5:0] OP_ALU5 = 6'b0101_00;
    localparam logic [5:0] OP_JZ   = 6'b1101_00;
    localparam logic [5:0] OP_JNZ  = 6'b1110_00;
    localparam logic [5:0] OP_CALL = 6'b1111_00;
    localparam logic [5:0] OP_RET  = 6'b1111_01;
    localparam logic [5:0] OP_HALT = 6'b1111_11;

    unidad_control_mc #(.OPW(6), .PCW(10), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
        .zero(zero), .pc_in(pc_in), .fetch_req(fetch_req), .s_inc(s_inc),
        .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op), .s_pc(s_pc),
        .pc_we(pc_we), .ret_addr(ret_addr), .halted(halted), .stack_err(stack_err)
    );

    assign ctl = {fetch_req, s_inc, s_inm, we3, wez, Op, s_pc, pc_we};

    always #5 clk = ~clk;

    // Present one opcode in FETCH; returns 1ns into the following EXEC cycle.
    task automatic issue(input logic [5:0] op, input logic z, input logic [9:0] pc);
        @(negedge clk);
        opcode = op; instr_valid = 1'b1; zero = z; pc_in = pc;
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        total++;
        if (ctl !== C_ZERO) $display("FAIL reset_ctl got=%b exp=%b", ctl, C_ZERO);
        else passed++;
        total++;
        if ({halted, stack_err, ret_addr} !== 12'd0)
            $display("FAIL reset_status got=%b exp=0", {halted, stack_err, ret_addr});
        else passed++;
        @(negedge clk); reset = 1'b1; #1;
        total++;
        if (ctl !== C_FETCH) $display("FAIL reset_first_fetch got=%b exp=%b", ctl, C_FETCH);
        else passed++;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); instr_valid = 1'b0; opcode = OP_ADI; #1;
            total++;
            if (ctl !== C_FETCH) $display("FAIL idle_%0d got=%b exp=%b", i, ctl, C_FETCH);
            else passed++;
        end
    endtask

    task automatic test_alu_imm();
        issue(OP_ADI, 1'b0, 10'd0);
        total++;
        if (ctl !== C_ADI) $display("FAIL adi_exec got=%b exp=%b", ctl, C_ADI);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (ctl !== C_FETCH) $display("FAIL adi_back_to_fetch got=%b exp=%b", ctl, C_FETCH);
        else passed++;
        issue(OP_LI, 1'b0, 10'd0);
        total++;
        if (ctl !== C_LI) $display("FAIL li_exec got=%b exp=%b", ctl, C_LI);
        else passed++;
    endtask

    task automatic test_jumps();
        issue(OP_ALU5, 1'b1, 10'd0);
        total++;
        if (ctl !== C_ALU5) $display("FAIL alu5_exec got=%b exp=%b", ctl, C_ALU5);
        else passed++;
        issue(OP_JZ, 1'b0, 10'd0);
        total++;
        if (ctl !== C_JUMP) $display("FAIL jz_taken got=%b exp=%b", ctl, C_JUMP);
        else passed++;
        issue(OP_ALU5, 1'b0, 10'd0);
        issue(OP_JZ, 1'b1, 10'd0);
        total++;
        if (ctl !== C_SEQ) $display("FAIL jz_not_taken got=%b exp=%b", ctl, C_SEQ);
        else passed++;
        issue(OP_JNZ, 1'b1, 10'd0);
        total++;
        if (ctl !== C_JUMP) $display("FAIL jnz_taken got=%b exp=%b", ctl, C_JUMP);
        else passed++;
    endtask

    task automatic test_call_ret();
        issue(OP_CALL, 1'b0, 10'd5);
        total++;
        if (ctl !== C_JUMP) $display("FAIL call_exec got=%b exp=%b", ctl, C_JUMP);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (ret_addr !== 10'd6) $display("FAIL call_ret_addr got=%0d exp=6", ret_addr);
        else passed++;
        issue(OP_RET, 1'b0, 10'd9);
        total++;
        if (ctl !== C_RET) $display("FAIL ret_exec got=%b exp=%b", ctl, C_RET);
        else passed++;
        @(negedge clk); #1;
        total++;
        if ({stack_err, ret_addr} !== 11'd0)
            $display("FAIL ret_after got=%b exp=0", {stack_err, ret_addr});
        else passed++;
    endtask

    task automatic test_stack_err();
        for (int i = 0; i < 4; i++) issue(OP_CALL, 1'b0, 10'(10 + i));
        issue(OP_CALL, 1'b0, 10'd20);
        total++;
        if ({ctl, stack_err} !== {C_SEQ, 1'b1})
            $display("FAIL call_overflow got=%b exp=%b", {ctl, stack_err}, {C_SEQ, 1'b1});
        else passed++;
        @(negedge clk); #1;
        total++;
        if ({stack_err, ret_addr} !== {1'b1, 10'd14})
            $display("FAIL overflow_sticky got=%b/%0d exp=1/14", stack_err, ret_addr);
        else passed++;
        pulse_reset();
        total++;
        if ({stack_err, ret_addr} !== 11'd0)
            $display("FAIL reset_clears_stack got=%b exp=0", {stack_err, ret_addr});
        else passed++;
        issue(OP_RET, 1'b0, 10'd0);
        total++;
        if ({ctl, stack_err} !== {C_SEQ, 1'b1})
            $display("FAIL ret_underflow got=%b exp=%b", {ctl, stack_err}, {C_SEQ, 1'b1});
        else passed++;
    endtask

    task automatic test_reset_mid_exec();
        pulse_reset();
        issue(OP_ADI, 1'b1, 10'd0);
        reset = 1'b0; #1;
        total++;
        if (ctl !== C_ZERO) $display("FAIL reset_mid_exec got=%b exp=%b", ctl, C_ZERO);
        else passed++;
        @(negedge clk); reset = 1'b1; #1;
        total++;
        if (ctl !== C_FETCH) $display("FAIL reset_mid_exec_fetch got=%b exp=%b", ctl, C_FETCH);
        else passed++;
        issue(OP_JZ, 1'b0, 10'd0);
        total++;
        if (ctl !== C_SEQ) $display("FAIL zflag_not_loaded got=%b exp=%b", ctl, C_SEQ);
        else passed++;
    endtask

    task automatic test_halt();
        issue(OP_HALT, 1'b0, 10'd0);
        total++;
        if (ctl !== C_ZERO) $display("FAIL halt_exec got=%b exp=%b", ctl, C_ZERO);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); opcode = OP_LI; instr_valid = 1'b1; #1;
            total++;
            if ({ctl, halted} !== {C_ZERO, 1'b1})
                $display("FAIL halted_%0d got=%b exp=%b", i, {ctl, halted}, {C_ZERO, 1'b1});
            else passed++;
        end
        @(negedge clk); reset = 1'b0; instr_valid = 1'b0; #1;
        total++;
        if (halted !== 1'b0) $display("FAIL halt_reset_forced got=%b exp=0", halted);
        else passed++;
        @(negedge clk); reset = 1'b1; #1;
        total++;
        if ({ctl, halted} !== {C_FETCH, 1'b0})
            $display("FAIL halt_exit got=%b exp=%b", {ctl, halted}, {C_FETCH, 1'b0});
        else passed++;
    endtask

    initial begin
        reset = 1'b0; opcode = '0; instr_valid = 1'b0; zero = 1'b0; pc_in = '0;
        test_reset();
        test_idle();
        test_alu_imm();
        test_jumps();
        test_call_ret();
        test_stack_err();
        test_reset_mid_exec();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
